// File: rtl/banco_registros_sb.sv
// N x Bits register file with two combinational read ports, one write-back port and a busy-bit scoreboard.
// Reads and stall are combinational; reservations/releases appear the cycle after the edge; stall refuses issue.
module banco_registros_sb #(
  parameter int N        = 32,
  parameter int Bits     = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [$clog2(N)-1:0]  ptr_rd_1,
  input  logic [$clog2(N)-1:0]  ptr_rd_2,
  output logic [Bits-1:0]       data_rd_1,
  output logic [Bits-1:0]       data_rd_2,
  input  logic [$clog2(N)-1:0]  ptr_wr,
  input  logic [Bits-1:0]       data_wr,
  input  logic                  wr_en,
  input  logic                  iss_en,
  input  logic [$clog2(N)-1:0]  ptr_iss,
  input  logic [1:0]            iss_rs_use,
  output logic                  stall,
  output logic [$clog2(N):0]    busy_cnt,
  output logic                  err_wb
);

  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;

  logic [Bits-1:0] regs [N];
  logic [N-1:0]    busy, busy_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic            err_q;

  logic byp_1, byp_2, raw_1, raw_2, waw;
  logic reserve, wr_ok, rel, wb_err;

  function automatic logic is_zero(input logic [AW-1:0] p);
    return (ZERO_REG != 0) && (p == '0);
  endfunction

  always_comb begin
    byp_1 = (BYPASS != 0) && wr_en && (ptr_wr == ptr_rd_1) && !is_zero(ptr_rd_1);
    byp_2 = (BYPASS != 0) && wr_en && (ptr_wr == ptr_rd_2) && !is_zero(ptr_rd_2);

    data_rd_1 = is_zero(ptr_rd_1) ? '0 : (byp_1 ? data_wr : regs[ptr_rd_1]);
    data_rd_2 = is_zero(ptr_rd_2) ? '0 : (byp_2 ? data_wr : regs[ptr_rd_2]);

    // A forwarded write-back resolves RAW; any write-back to ptr_iss resolves WAW.
    raw_1 = iss_rs_use[0] && busy[ptr_rd_1] && !byp_1;
    raw_2 = iss_rs_use[1] && busy[ptr_rd_2] && !byp_2;
    waw   = busy[ptr_iss] && !(wr_en && (ptr_wr == ptr_iss));
    stall = iss_en && (raw_1 || raw_2 || waw);

    reserve = iss_en && !stall && !is_zero(ptr_iss);
    wr_ok   = wr_en && !is_zero(ptr_wr);
    rel     = wr_ok && busy[ptr_wr];
    wb_err  = wr_ok && !busy[ptr_wr];
  end

  // Release before reserve so a same-register issue wins.
  always_comb begin
    busy_nxt = busy;
    if (rel)
      busy_nxt[ptr_wr] = 1'b0;
    if (reserve)
      busy_nxt[ptr_iss] = 1'b1;

    cnt_nxt = cnt_q;
    case ({reserve, rel})
      2'b10:   cnt_nxt = cnt_q + CW'(1);
      2'b01:   cnt_nxt = cnt_q - CW'(1);
      default: cnt_nxt = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        regs[i] <= '0;
      busy  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (wr_ok)
        regs[ptr_wr] <= data_wr;
      busy  <= busy_nxt;
      cnt_q <= cnt_nxt;
      if (wb_err)
        err_q <= 1'b1;
    end
  end

  assign busy_cnt = cnt_q;
  assign err_wb   = err_q;

endmodule

// File: tb/tb_banco_registros_sb.sv
// Bench for banco_registros_sb: one BYPASS=1 and one BYPASS=0 instance on shared inputs,
// directed scenarios plus randomized traffic against a set-based reference model.
module tb_banco_registros_sb;

  localparam int N  = 32;
  localparam int B  = 32;
  localparam int AW = $clog2(N);

  logic          clk;
  logic          rst;
  logic [AW-1:0] ptr_rd_1, ptr_rd_2, ptr_wr, ptr_iss;
  logic [B-1:0]  data_wr;
  logic          wr_en, iss_en;
  logic [1:0]    iss_rs_use;

  // index 1 = BYPASS=1 instance, index 0 = BYPASS=0 instance
  logic [B-1:0]  d1_o [2];
  logic [B-1:0]  d2_o [2];
  logic          stall_o [2];
  logic [AW:0]   cnt_o [2];
  logic          err_o [2];

  int checks = 0;
  int errors = 0;

  banco_registros_sb #(.N(N), .Bits(B), .ZERO_REG(1), .BYPASS(1)) dut_b1 (
    .clk(clk), .rst(rst),
    .ptr_rd_1(ptr_rd_1), .ptr_rd_2(ptr_rd_2),
    .data_rd_1(d1_o[1]), .data_rd_2(d2_o[1]),
    .ptr_wr(ptr_wr), .data_wr(data_wr), .wr_en(wr_en),
    .iss_en(iss_en), .ptr_iss(ptr_iss), .iss_rs_use(iss_rs_use),
    .stall(stall_o[1]), .busy_cnt(cnt_o[1]), .err_wb(err_o[1])
  );

  banco_registros_sb #(.N(N), .Bits(B), .ZERO_REG(1), .BYPASS(0)) dut_b0 (
    .clk(clk), .rst(rst),
    .ptr_rd_1(ptr_rd_1), .ptr_rd_2(ptr_rd_2),
    .data_rd_1(d1_o[0]), .data_rd_2(d2_o[0]),
    .ptr_wr(ptr_wr), .data_wr(data_wr), .wr_en(wr_en),
    .iss_en(iss_en), .ptr_iss(ptr_iss), .iss_rs_use(iss_rs_use),
    .stall(stall_o[0]), .busy_cnt(cnt_o[0]), .err_wb(err_o[0])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: register contents, the set of reserved registers, sticky error.
  logic [B-1:0] m_reg  [2][N];
  bit           m_busy [2][N];
  bit           m_err  [2];

  function automatic logic [B-1:0] m_read(int b, logic [AW-1:0] p);
    if (p == 0) return '0;
    if (b == 1 && wr_en && ptr_wr == p) return data_wr;
    return m_reg[b][p];
  endfunction

  function automatic bit m_stall(int b);
    bit fwd1, fwd2, raw1, raw2, waw;
    if (!iss_en) return 1'b0;
    fwd1 = (b == 1) && wr_en && ptr_wr == ptr_rd_1;
    fwd2 = (b == 1) && wr_en && ptr_wr == ptr_rd_2;
    raw1 = iss_rs_use[0] && m_busy[b][ptr_rd_1] && !fwd1;
    raw2 = iss_rs_use[1] && m_busy[b][ptr_rd_2] && !fwd2;
    waw  = m_busy[b][ptr_iss] && !(wr_en && ptr_wr == ptr_iss);
    return raw1 || raw2 || waw;
  endfunction

  function automatic int m_count(int b);
    int c = 0;
    for (int i = 0; i < N; i++) c += m_busy[b][i];
    return c;
  endfunction

  task automatic m_clear();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < N; i++) begin
        m_reg[b][i]  = '0;
        m_busy[b][i] = 1'b0;
      end
      m_err[b] = 1'b0;
    end
  endtask

  task automatic m_edge();
    bit acc [2];
    for (int b = 0; b < 2; b++)
      acc[b] = iss_en && !m_stall(b) && ptr_iss != 0;
    for (int b = 0; b < 2; b++) begin
      if (wr_en && ptr_wr != 0) begin
        if (!m_busy[b][ptr_wr]) m_err[b] = 1'b1;
        m_reg[b][ptr_wr]  = data_wr;
        m_busy[b][ptr_wr] = 1'b0;
      end
      if (acc[b]) m_busy[b][ptr_iss] = 1'b1;
    end
  endtask

  task automatic idle();
    ptr_rd_1 = '0; ptr_rd_2 = '0; ptr_wr = '0; ptr_iss = '0;
    data_wr = '0; wr_en = 1'b0; iss_en = 1'b0; iss_rs_use = 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (cnt_o[b] !== 0 || err_o[b] !== 1'b0) begin
        errors++;
        $display("FAIL reset_init[%0d]: cnt=%0d err=%b, want cnt=0 err=0", b, cnt_o[b], err_o[b]);
      end
    end
    wr_en = 1'b1; ptr_wr = 5; data_wr = 32'hDEAD;
    tick();
    idle();
    iss_en = 1'b1; ptr_iss = 5;
    tick();
    idle();
    ptr_rd_1 = 5;
    #1;
    checks++;
    if (cnt_o[1] !== 1 || d1_o[1] !== 32'hDEAD) begin
      errors++;
      $display("FAIL pre_reset: cnt=%0d rd=%h, want cnt=1 rd=0000dead", cnt_o[1], d1_o[1]);
    end
    rst = 1'b1;
    #2;
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (cnt_o[b] !== 0 || err_o[b] !== 1'b0 || d1_o[b] !== '0) begin
        errors++;
        $display("FAIL async_reset[%0d]: cnt=%0d err=%b rd=%h, want 0 0 0", b, cnt_o[b], err_o[b], d1_o[b]);
      end
    end
    wr_en = 1'b1; ptr_wr = 5; data_wr = 32'hBEEF;
    tick();
    rst = 1'b0;
    wr_en = 1'b0;
    iss_en = 1'b1; ptr_iss = 6; iss_rs_use = 2'b01;
    #1;
    checks++;
    if (d1_o[1] !== '0 || stall_o[1] !== 1'b0 || err_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL write_in_reset: rd=%h stall=%b err=%b, want 0 0 0", d1_o[1], stall_o[1], err_o[1]);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    do_reset();
    wr_en = 1'b1; ptr_wr = 0; data_wr = 32'hFFFF_FFFF; ptr_rd_1 = 0;
    #1;
    checks++;
    if (d1_o[1] !== '0) begin
      errors++;
      $display("FAIL zero_bypass: rd=%h, want 0", d1_o[1]);
    end
    tick();
    idle();
    ptr_rd_1 = 0; ptr_rd_2 = 0;
    iss_en = 1'b1; ptr_iss = 0; iss_rs_use = 2'b11;
    #1;
    checks++;
    if (d1_o[1] !== '0 || stall_o[1] !== 1'b0 || err_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL zero_read: rd=%h stall=%b err=%b, want 0 0 0", d1_o[1], stall_o[1], err_o[1]);
    end
    tick();
    idle();
    checks++;
    if (cnt_o[1] !== 0 || cnt_o[0] !== 0) begin
      errors++;
      $display("FAIL zero_issue_cnt: cnt=%0d/%0d, want 0", cnt_o[1], cnt_o[0]);
    end
  endtask

  task automatic test_raw_bypass();
    do_reset();
    iss_en = 1'b1; ptr_iss = 3;
    tick();
    checks++;
    if (cnt_o[1] !== 1 || cnt_o[0] !== 1) begin
      errors++;
      $display("FAIL raw_reserve: cnt=%0d/%0d, want 1", cnt_o[1], cnt_o[0]);
    end
    ptr_iss = 4; iss_rs_use = 2'b01; ptr_rd_1 = 3;
    #1;
    checks++;
    if (stall_o[1] !== 1'b1 || stall_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL raw_stall: stall=%b/%b, want 1", stall_o[1], stall_o[0]);
    end
    wr_en = 1'b1; ptr_wr = 3; data_wr = 32'h1234;
    #1;
    checks++;
    if (stall_o[1] !== 1'b0 || d1_o[1] !== 32'h1234) begin
      errors++;
      $display("FAIL raw_bypass: stall=%b rd=%h, want 0 00001234", stall_o[1], d1_o[1]);
    end
    checks++;
    if (stall_o[0] !== 1'b1 || d1_o[0] !== '0) begin
      errors++;
      $display("FAIL raw_nobypass: stall=%b rd=%h, want 1 0", stall_o[0], d1_o[0]);
    end
    tick();
    idle();
    ptr_rd_1 = 3;
    #1;
    checks++;
    if (cnt_o[1] !== 1 || cnt_o[0] !== 0 || d1_o[0] !== 32'h1234) begin
      errors++;
      $display("FAIL raw_after: cnt=%0d/%0d rd0=%h, want 1/0 00001234", cnt_o[1], cnt_o[0], d1_o[0]);
    end
  endtask

  task automatic test_waw();
    do_reset();
    iss_en = 1'b1; ptr_iss = 7;
    tick();
    #1;
    checks++;
    if (stall_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL waw_stall: stall=%b, want 1", stall_o[1]);
    end
    tick();
    idle();
    checks++;
    if (cnt_o[1] !== 1) begin
      errors++;
      $display("FAIL waw_cnt: cnt=%0d, want 1", cnt_o[1]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    iss_en = 1'b1; ptr_iss = 9;
    tick();
    wr_en = 1'b1; ptr_wr = 9; data_wr = 32'h55;
    #1;
    checks++;
    if (stall_o[1] !== 1'b0 || stall_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL same_reg_stall: stall=%b/%b, want 0", stall_o[1], stall_o[0]);
    end
    tick();
    idle();
    ptr_rd_1 = 9; iss_en = 1'b1; ptr_iss = 9;
    #1;
    checks++;
    if (d1_o[1] !== 32'h55 || cnt_o[1] !== 1 || stall_o[1] !== 1'b1 || err_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL same_reg: rd=%h cnt=%0d stall=%b err=%b, want 00000055 1 1 0",
               d1_o[1], cnt_o[1], stall_o[1], err_o[1]);
    end
    idle();
  endtask

  task automatic test_unreserved_wb();
    do_reset();
    wr_en = 1'b1; ptr_wr = 12; data_wr = 32'hA5;
    tick();
    idle();
    ptr_rd_1 = 12;
    tick(); tick();
    checks++;
    if (err_o[1] !== 1'b1 || err_o[0] !== 1'b1 || d1_o[1] !== 32'hA5 || cnt_o[1] !== 0) begin
      errors++;
      $display("FAIL unreserved_wb: err=%b/%b rd=%h cnt=%0d, want 1/1 000000a5 0",
               err_o[1], err_o[0], d1_o[1], cnt_o[1]);
    end
    do_reset();
    checks++;
    if (err_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b, want 0", err_o[1]);
    end
  endtask

  task automatic test_random();
    do_reset();
    m_clear();
    for (int cyc = 0; cyc < 600; cyc++) begin
      ptr_rd_1   = AW'($urandom_range(0, 7));
      ptr_rd_2   = AW'($urandom_range(0, 7));
      ptr_wr     = AW'($urandom_range(0, 7));
      ptr_iss    = AW'($urandom_range(0, 7));
      data_wr    = $urandom;
      wr_en      = ($urandom_range(0, 2) == 0);
      iss_en     = ($urandom_range(0, 1) == 0);
      iss_rs_use = 2'($urandom);
      #4;
      for (int b = 0; b < 2; b++) begin
        checks++;
        if (d1_o[b] !== m_read(b, ptr_rd_1) || d2_o[b] !== m_read(b, ptr_rd_2) ||
            stall_o[b] !== m_stall(b)) begin
          errors++;
          $display("FAIL rand_comb[%0d] cyc %0d: rd1=%h rd2=%h stall=%b, want %h %h %b", b, cyc,
                   d1_o[b], d2_o[b], stall_o[b], m_read(b, ptr_rd_1), m_read(b, ptr_rd_2), m_stall(b));
        end
      end
      @(posedge clk);
      m_edge();
      #1;
      for (int b = 0; b < 2; b++) begin
        checks++;
        if (cnt_o[b] !== (AW+1)'(m_count(b)) || err_o[b] !== m_err[b]) begin
          errors++;
          $display("FAIL rand_seq[%0d] cyc %0d: cnt=%0d err=%b, want %0d %b", b, cyc,
                   cnt_o[b], err_o[b], m_count(b), m_err[b]);
        end
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    test_reset();
    test_zero_reg();
    test_raw_bypass();
    test_waw();
    test_back_to_back();
    test_unreserved_wb();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/banco_registros_sb.md
Name: banco_registros_sb

Overview:
- Parametrised successor to the single-issue register bank: N x Bits register file with two combinational read ports, one write-back port, optional hardwired-zero register 0 and optional write-to-read bypass.
- Adds a per-register scoreboard (busy bits) so the RISC-V pipeline can reserve a destination at issue, release it at write-back, and stall on RAW/WAW hazards.
- Sits between decode/issue and write-back in the processor datapath.

Parameters:
- N, 32, number of registers (power of two, >= 2).
- Bits, 32, register width.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never reserved.
- BYPASS, 1, 1 = a same-cycle write to a read register is forwarded to the read data.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ptr_rd_1  input  $clog2(N)  rs1 pointer.
- ptr_rd_2  input  $clog2(N)  rs2 pointer.
- data_rd_1  output  Bits  rs1 data (combinational).
- data_rd_2  output  Bits  rs2 data (combinational).
- ptr_wr  input  $clog2(N)  write-back destination.
- data_wr  input  Bits  write-back data.
- wr_en  input  1  write-back enable; releases the busy bit of ptr_wr.
- iss_en  input  1  issue request; reserves ptr_iss.
- ptr_iss  input  $clog2(N)  destination being issued.
- iss_rs_use  input  2  bit0/bit1 = issuing instruction reads rs1/rs2.
- stall  output  1  hazard; issue is refused this cycle (combinational).
- busy_cnt  output  $clog2(N)+1  number of busy registers (registered).
- err_wb  output  1  sticky: write-back to a non-busy register.

Behaviour:
- Reset (async, rst=1): all registers = 0, all busy bits = 0, busy_cnt = 0, err_wb = 0. Read data then reflects zeros. A reset mid-operation drops all reservations immediately. No write takes effect while rst=1.
- Write: on a rising edge with wr_en=1, reg[ptr_wr] <= data_wr. Exception: when ZERO_REG=1 and ptr_wr=0, the write is dropped.
- Read: data_rd_k = reg[ptr_rd_k], or 0 when ZERO_REG=1 and the pointer is 0.
  - BYPASS=1 and wr_en=1 and ptr_wr==ptr_rd_k (not the zero register): data_rd_k = data_wr.
  - BYPASS=0: the old value is returned until the next cycle.
- Hazard for rs_k: iss_rs_use[k]=1 and busy[ptr_rd_k]=1, unless (BYPASS=1 and wr_en=1 and ptr_wr==ptr_rd_k).
- WAW hazard: busy[ptr_iss]=1 and not (wr_en=1 and ptr_wr==ptr_iss).
- stall = iss_en & (RAW1 | RAW2 | WAW). stall = 0 when iss_en=0.
- Issue accepted = iss_en & ~stall. On a clock edge busy[ptr_iss] <= 1, except for register 0 when ZERO_REG=1 (no reservation, no stall from reg 0).
- Release: on a clock edge with wr_en=1 and busy[ptr_wr]=1, busy[ptr_wr] <= 0.
- Simultaneous accepted issue and write-back to the same register: data is written and busy ends at 1 (issue wins).
- wr_en=1 to a register with busy=0 (excluding reg 0 under ZERO_REG): data is still written and err_wb sets to 1. err_wb clears only on rst.
- busy_cnt next = busy_cnt + accepted_issue_reserves − release. Net 0 when both hit the same register. Never wraps: range 0..N−1 with ZERO_REG, 0..N otherwise.
- Latency: reservation and release become visible on busy/stall the cycle after the edge. Read data is combinational, zero latency.

Test Plan:
- Reset then read: assert rst mid-run with x5 busy and reg[5]=0xDEAD → data_rd_1(ptr 5)=0, stall=0 for issue reading x5, busy_cnt=0, err_wb=0.
- Zero register: wr_en, ptr_wr=0, data 0xFFFF_FFFF; then issue ptr_iss=0 → data_rd_1(ptr 0)=0, stall=0, busy_cnt unchanged.
- RAW stall and bypass release: issue rd=x3 (busy_cnt=1). Next cycle, issue reading rs1=x3 → stall=1. Same cycle as wr_en ptr_wr=3 data 0x1234 → stall=0, data_rd_1=0x1234 (BYPASS=1); with BYPASS=0, stall=1 and old value returned.
- WAW stall: issue rd=x7 accepted. Next cycle issue rd=x7 with no write-back → stall=1, busy_cnt stays 1.
- Simultaneous issue and write-back on x9 (x9 busy): wr_en ptr_wr=9 data 0x55, iss_en ptr_iss=9 → accepted, reg[9]=0x55, busy[9]=1, busy_cnt unchanged.
- Unreserved write-back: wr_en ptr_wr=12 data 0xA5 with x12 not busy → reg[12]=0xA5, err_wb=1 and stays 1 until rst.
